// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int INS_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [INS_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; serves as both the instruction queue and the PC side-queue.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0] rd, wr;

  assign dout = mem[rd];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count == '0));
endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: PC, credit-limited SRAM requests, in-order response queue, and
// redirect with drop of stale in-flight responses.
module ins_fetch import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetchEn,
  input  logic             redirect,
  input  logic [31:0]      redirectPc,
  output logic             imemReq,
  output logic [31:0]      imemAddr,
  input  logic             imemGnt,
  input  logic             imemRvalid,
  input  logic [INS_W-1:0] imemRdata,
  output logic [INS_W-1:0] ins,
  output logic [31:0]      insPc,
  output logic             insValid,
  input  logic             insReady
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e  state;
  logic [31:0]   pc, aq_pc;
  logic [CW-1:0] outstanding, drop_cnt, count, aq_count, out_net;
  logic [CW:0]   credit;
  logic          grant, drop, accept, pop;
  fetch_entry_t  push_ent, head;

  // Buffered plus in-flight words may never exceed the queue depth.
  assign credit   = {1'b0, count} + {1'b0, outstanding};
  assign imemReq  = (state != IDLE) && fetchEn && !redirect && (credit < DEPTH_C);
  assign imemAddr = pc;
  assign grant    = imemReq && imemGnt;
  assign drop     = imemRvalid && (redirect || drop_cnt != '0);
  assign accept   = imemRvalid && !drop;
  assign pop      = insValid && insReady && !redirect;
  assign out_net  = outstanding - CW'(imemRvalid);

  assign push_ent = '{ins: imemRdata, pc: aq_pc};
  assign ins      = head.ins;
  assign insPc    = head.pc;
  assign insValid = (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(imemRvalid);
      if (redirect) begin
        pc       <= redirectPc & ~32'h3;
        drop_cnt <= out_net;
        state    <= (out_net != '0) ? DRAIN : (fetchEn ? RUN : IDLE);
      end else begin
        if (grant) pc <= pc + PC_STEP;
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        case (state)
          IDLE:    if (fetchEn) state <= RUN;
          RUN:     if (!fetchEn && drop_cnt == '0) state <= IDLE;
          DRAIN:   if (drop_cnt == '0 || (drop_cnt == CW'(1) && imemRvalid))
                     state <= fetchEn ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(.W(2*INS_W), .DEPTH(DEPTH)) u_ins_q (
    .clk(clk), .rst(rst), .push(accept), .pop(pop), .flush(redirect),
    .din(push_ent), .dout(head), .count(count)
  );

  fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_pc_q (
    .clk(clk), .rst(rst), .push(grant), .pop(accept), .flush(redirect),
    .din(pc), .dout(aq_pc), .count(aq_count)
  );

  a_pc_known: assert property (@(posedge clk) disable iff (rst)
    accept |-> aq_count != '0);
endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage that sits directly upstream of the single-cycle `Cpu` core and drives its `ins` input. It keeps the program counter and issues in-order read requests to the instruction SRAM over a request/grant port. Returned words go into a small FIFO, which feeds the core through a valid/ready handshake. It also supports a redirect (PC load) that flushes the FIFO and discards in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset; bits [1:0] are forced to 0.
- `DEPTH`, 4, FIFO entries and also the maximum number of outstanding requests (power of 2, ≥2).
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetchEn`  in  1  when high, new requests may be issued.
- `redirect`  in  1  single-cycle pulse that loads `redirectPc`.
- `redirectPc`  in  32  new fetch address; bits [1:0] are ignored.
- `imemReq`  out  1  request valid.
- `imemAddr`  out  32  word-aligned request address (= PC).
- `imemGnt`  in  1  SRAM accepts the request this cycle.
- `imemRvalid`  in  1  response valid; responses return in order, ≥1 cycle after grant.
- `imemRdata`  in  32  response word.
- `ins`  out  32  FIFO head instruction.
- `insPc`  out  32  PC of `ins`.
- `insValid`  out  1  FIFO is not empty.
- `insReady`  in  1  core consumes `ins` this cycle.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `fetchEn`=1.
  - RUN → IDLE when `fetchEn`=0 and there is no drop pending.
  - Any state → DRAIN on `redirect` while `outstanding` (net of a response arriving that cycle) > 0.
  - DRAIN → RUN (or IDLE if `fetchEn`=0) when `dropCnt` reaches 0.
  - On a redirect with nothing outstanding, go directly to RUN or IDLE.
- Request issue:
  - `imemReq` = state≠IDLE & `fetchEn` & ~`redirect` & (`count` + `outstanding` < DEPTH).
  - Requests may be issued during DRAIN, at the new PC.
- Counters:
  - On grant (`imemReq` & `imemGnt`): PC ← PC+4 (32-bit wrap, 0xFFFF_FFFC → 0), `outstanding`++, and the request's PC is pushed into an address side-queue.
  - On `imemRvalid`: `outstanding`--.
  - If `dropCnt`>0, the response is discarded and `dropCnt`--. Otherwise the data and its queued PC are pushed into the FIFO.
- Redirect, applied in the same cycle:
  - FIFO and PC side-queue cleared; `count` ← 0.
  - PC ← {`redirectPc`[31:2], 2'b00}.
  - `dropCnt` ← `outstanding` − (`imemRvalid` ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - Any pop in that cycle is ignored.
- Pop on `insValid` & `insReady`.
  - Simultaneous push and pop leaves `count` unchanged.
  - The credit rule guarantees a push never hits a full FIFO; a response arriving while full is an assertion failure.
- Counter widths: `count`, `outstanding` and `dropCnt` are $clog2(DEPTH+1) bits.

## Timing
- Reset values:
  - state=IDLE; PC=`RESET_PC`; `count`, `outstanding` and `dropCnt` = 0.
  - `imemReq`=0, `imemAddr`=`RESET_PC`, `insValid`=0, `ins`=0, `insPc`=0.
- Reset asserted mid-operation drops everything immediately. Responses that arrive after reset deasserts for requests issued before reset are not supported; the SRAM is reset together with this block.
- `imemAddr` is the registered PC and is stable while `imemReq`=1 and not granted.
- Latency: a response in cycle N → `insValid`=1 in cycle N+1.
  - Grant-to-core minimum is 2 cycles with a 1-cycle SRAM.
- With 1-cycle SRAM latency and `insReady`=1, throughput is 1 instruction per cycle.
- `redirect` in cycle N → `imemReq` at `redirectPc` in N+1 and `insValid`=0 in N+1.

## Structure
- Shared package `fetch_pkg`: `fetch_state_e` (IDLE/RUN/DRAIN), `INS_W`=32, `PC_STEP`=4.
- One sub-module, `fetch_fifo`: a synchronous FIFO of DEPTH entries × 64 bits (data, PC) with push/pop/flush and a count output. The address side-queue is a second instance of the same sub-module, 32 bits wide.

## Test plan
- Reset, `fetchEn`=1, 1-cycle SRAM, `insReady`=1 → PCs 0x0, 0x4, 0x8… delivered one per cycle starting 2 cycles after the first grant.
- `insReady`=0, SRAM always grants → exactly 4 grants issued, `imemReq` then held low, 4 entries held; release `insReady` → the 4 words delivered in order, then fetching resumes at 0x10.
- 3-cycle SRAM, redirect to 0x100 with 3 requests outstanding → those 3 responses are dropped, no `ins` is delivered with PC < 0x100, and the first delivered `insPc`=0x100.
- Redirect in the same cycle as `imemRvalid` and a pop → the response is dropped, `count`=0 next cycle, `dropCnt`=`outstanding`−1.
- PC wrap: `RESET_PC`=0xFFFF_FFF8 → request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- `rst` asserted mid-stream with 2 entries buffered → `insValid`=0 and `imemReq`=0 immediately; after deassertion, fetch restarts at `RESET_PC`.
